// File: rtl/gtxe2_chnl_tx_dataiface.sv
// ---------------------------------------------------------------------------
// gtxe2_chnl_tx_dataiface
//
// Purpose:
//   Transmit-side user data interface of the GTXE2 channel model. Wide user
//   words (data + K-flags) are accepted via a valid/ready handshake into a
//   small single-clock FIFO. Each word is then serialised, low slice first,
//   into `div` narrow words, one per usrclk cycle, for the TX encoder path.
//   The slice order is the inverse of the RX data interface packing, so a
//   loopback reproduces the original wide word.
//
// Ports:
//   usrclk     in   the only clock, rising edge
//   reset      in   synchronous, active-high
//   indata     in   wide data word
//   inisk      in   wide K-flags
//   inval      in   producer presents a word
//   inready    out  FIFO can accept (word moves on inval & inready)
//   outdata    out  registered narrow data slice
//   outisk     out  registered narrow K-flag slice
//   outval     out  outdata/outisk carry a real slice
//   phase      out  index of the slice currently on outdata
//   underflow  out  one-cycle pulse when a running stream runs dry
// ---------------------------------------------------------------------------
module gtxe2_chnl_tx_dataiface #(
  parameter int internal_data_width  = 16,
  parameter int interface_data_width = 32,
  parameter int internal_isk_width   = 2,
  parameter int interface_isk_width  = 4,
  parameter int log_depth            = 2,
  localparam int DIV     = interface_data_width / internal_data_width,
  localparam int PHASE_W = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic                            usrclk,
  input  logic                            reset,
  input  logic [interface_data_width-1:0] indata,
  input  logic [interface_isk_width-1:0]  inisk,
  input  logic                            inval,
  output logic                            inready,
  output logic [internal_data_width-1:0]  outdata,
  output logic [internal_isk_width-1:0]   outisk,
  output logic                            outval,
  output logic [PHASE_W-1:0]              phase,
  output logic                            underflow
);

  localparam int WORD_W = interface_data_width + interface_isk_width;
  localparam int DEPTH  = 2 ** log_depth;

  localparam logic [log_depth:0]   CNT_ONE    = (log_depth + 1)'(1);
  localparam logic [log_depth:0]   CNT_FULL   = (log_depth + 1)'(DEPTH);
  localparam logic [log_depth-1:0] PTR_ONE    = log_depth'(1);
  localparam logic [PHASE_W-1:0]   PHASE_ONE  = PHASE_W'(1);
  localparam logic [PHASE_W-1:0]   PHASE_LAST = PHASE_W'(DIV - 1);

  // -------------------------------------------------------------------------
  // FIFO storage and pointers
  // -------------------------------------------------------------------------
  logic [WORD_W-1:0]    mem [DEPTH];
  logic [log_depth-1:0] wr_ptr_q;
  logic [log_depth-1:0] rd_ptr_q;
  logic [log_depth:0]   count_q;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic load_point;

  logic [WORD_W-1:0]               head;
  logic [interface_data_width-1:0] head_data;
  logic [interface_isk_width-1:0]  head_isk;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign inready = ~full & ~reset;
  assign push    = inval & inready;

  // Words are stored as {data, isk}.
  assign head      = mem[rd_ptr_q];
  assign head_data = head[WORD_W-1:interface_isk_width];
  assign head_isk  = head[interface_isk_width-1:0];

  // -------------------------------------------------------------------------
  // Serialiser registers
  // -------------------------------------------------------------------------
  logic [interface_data_width-1:0] hold_data_q, hold_data_d;
  logic [interface_isk_width-1:0]  hold_isk_q,  hold_isk_d;
  logic [internal_data_width-1:0]  outdata_q,   outdata_d;
  logic [internal_isk_width-1:0]   outisk_q,    outisk_d;
  logic                            outval_q,    outval_d;
  logic [PHASE_W-1:0]              phase_q,     phase_d;
  logic                            underflow_q, underflow_d;

  // Shifted view of the holding register: the low slice of these is the
  // next slice to emit (slice phase+1 of the original word).
  logic [interface_data_width-1:0] hold_data_shr;
  logic [interface_isk_width-1:0]  hold_isk_shr;

  assign hold_data_shr = hold_data_q >> internal_data_width;
  assign hold_isk_shr  = hold_isk_q >> internal_isk_width;

  // IDLE, or the last slice of the current word is on the outputs.
  assign load_point = ~outval_q | (phase_q == PHASE_LAST);

  // Occupancy is the registered count, so a word pushed into an empty FIFO
  // cannot be popped on the same edge.
  assign pop = ~reset & load_point & ~empty;

  always_comb begin
    hold_data_d = hold_data_q;
    hold_isk_d  = hold_isk_q;
    outdata_d   = outdata_q;
    outisk_d    = outisk_q;
    outval_d    = outval_q;
    phase_d     = phase_q;
    underflow_d = 1'b0;

    if (load_point) begin
      phase_d = '0;
      if (!empty) begin
        hold_data_d = head_data;
        hold_isk_d  = head_isk;
        outdata_d   = head_data[internal_data_width-1:0];
        outisk_d    = head_isk[internal_isk_width-1:0];
        outval_d    = 1'b1;
      end else begin
        outdata_d   = '0;
        outisk_d    = '0;
        outval_d    = 1'b0;
        // Only a stream that was running can underflow.
        underflow_d = outval_q;
      end
    end else begin
      // The holding register is shifted down as slices go out, so the
      // next slice is always at the bottom.
      hold_data_d = hold_data_shr;
      hold_isk_d  = hold_isk_shr;
      outdata_d   = hold_data_shr[internal_data_width-1:0];
      outisk_d    = hold_isk_shr[internal_isk_width-1:0];
      phase_d     = phase_q + PHASE_ONE;
    end
  end

  always_ff @(posedge usrclk) begin
    if (reset) begin
      hold_data_q <= '0;
      hold_isk_q  <= '0;
      outdata_q   <= '0;
      outisk_q    <= '0;
      outval_q    <= 1'b0;
      phase_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      hold_data_q <= hold_data_d;
      hold_isk_q  <= hold_isk_d;
      outdata_q   <= outdata_d;
      outisk_q    <= outisk_d;
      outval_q    <= outval_d;
      phase_q     <= phase_d;
      underflow_q <= underflow_d;
    end
  end

  // -------------------------------------------------------------------------
  // FIFO pointer / occupancy maintenance
  // -------------------------------------------------------------------------
  always_ff @(posedge usrclk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array has no reset; push is already blocked during reset.
  always_ff @(posedge usrclk) begin
    if (push) mem[wr_ptr_q] <= {indata, inisk};
  end

  assign outdata   = outdata_q;
  assign outisk    = outisk_q;
  assign outval    = outval_q;
  assign phase     = phase_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_gtxe2_chnl_tx_dataiface.sv
// ---------------------------------------------------------------------------
// tb_gtxe2_chnl_tx_dataiface
//
// Two instances: A uses the default 32->16 configuration, B the 16->16
// (div == 1) configuration. The stimulus process pushes the expected narrow
// slices of every accepted word into a per-instance queue; an independent
// monitor per instance pops and compares whenever outval is high, and also
// checks idle outputs, the underflow pulse and inready against an occupancy
// count built from accepted words and observed slice-0 pops.
// ---------------------------------------------------------------------------
module tb_gtxe2_chnl_tx_dataiface;

  logic usrclk = 1'b0;
  always #5 usrclk = ~usrclk;

  logic reset = 1'b1;

  // Instance A: 32-bit wide words, two 16-bit slices
  logic [31:0] indata_a  = '0;
  logic [3:0]  inisk_a   = '0;
  logic        inval_a   = 1'b0;
  logic        inready_a;
  logic [15:0] outdata_a;
  logic [1:0]  outisk_a;
  logic        outval_a;
  logic [0:0]  phase_a;
  logic        underflow_a;

  // Instance B: div == 1
  logic [15:0] indata_b  = '0;
  logic [1:0]  inisk_b   = '0;
  logic        inval_b   = 1'b0;
  logic        inready_b;
  logic [15:0] outdata_b;
  logic [1:0]  outisk_b;
  logic        outval_b;
  logic [0:0]  phase_b;
  logic        underflow_b;

  gtxe2_chnl_tx_dataiface dut_a (
    .usrclk    (usrclk),
    .reset     (reset),
    .indata    (indata_a),
    .inisk     (inisk_a),
    .inval     (inval_a),
    .inready   (inready_a),
    .outdata   (outdata_a),
    .outisk    (outisk_a),
    .outval    (outval_a),
    .phase     (phase_a),
    .underflow (underflow_a)
  );

  gtxe2_chnl_tx_dataiface #(
    .internal_data_width  (16),
    .interface_data_width (16),
    .internal_isk_width   (2),
    .interface_isk_width  (2),
    .log_depth            (2)
  ) dut_b (
    .usrclk    (usrclk),
    .reset     (reset),
    .indata    (indata_b),
    .inisk     (inisk_b),
    .inval     (inval_b),
    .inready   (inready_b),
    .outdata   (outdata_b),
    .outisk    (outisk_b),
    .outval    (outval_b),
    .phase     (phase_b),
    .underflow (underflow_b)
  );

  typedef struct {
    logic [15:0] d;
    logic [1:0]  k;
    logic [1:0]  ph;
  } slice_t;

  slice_t qa[$];
  slice_t qb[$];

  int n_chk  = 0;
  int n_fail = 0;

  // Occupancy bookkeeping: words accepted, words popped (slice 0 seen),
  // and whether a word was accepted at the most recent edge.
  int acca = 0, popa = 0, acc_last_a = 0;
  int accb = 0, popb = 0, acc_last_b = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus. Inputs change 1 time unit after posedge,
  // acceptance is decided from inready sampled at the negedge before the edge.
  task automatic step(input bit sel, input bit v, input logic [31:0] d,
                      input logic [3:0] k, output bit acc);
    if (!sel) begin
      inval_a = v; indata_a = d; inisk_a = k; inval_b = 1'b0;
    end else begin
      inval_b = v; indata_b = d[15:0]; inisk_b = k[1:0]; inval_a = 1'b0;
    end
    @(negedge usrclk);
    acc = v && (sel ? inready_b : inready_a);
    @(posedge usrclk);
    if (acc && !sel) begin
      for (int i = 0; i < 2; i++) qa.push_back('{d[16*i +: 16], k[2*i +: 2], 2'(i)});
      acca++;
      $display("push A data=%h isk=%b", d, k);
    end
    if (acc && sel) begin
      qb.push_back('{d[15:0], k[1:0], 2'd0});
      accb++;
      $display("push B data=%h isk=%b", d[15:0], k[1:0]);
    end
    acc_last_a = (acc && !sel) ? 1 : 0;
    acc_last_b = (acc && sel) ? 1 : 0;
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 4'h0, acc);
  endtask

  // Push one word, retrying while the FIFO is full (bounded).
  task automatic push_word(input bit sel, input logic [31:0] d, input logic [3:0] k);
    bit acc;
    acc = 1'b0;
    for (int t = 0; t < 40 && !acc; t++) step(sel, 1'b1, d, k, acc);
    check("push_accept", 32'(acc), 32'd1);
  endtask

  // ------------------------------------------------------------------ monitor A
  initial begin : mon_a
    bit     rst_e;
    bit     prev_v;
    slice_t e;
    prev_v = 1'b0;
    forever begin
      @(posedge usrclk);
      rst_e = reset;
      @(negedge usrclk);
      if (rst_e) begin
        qa.delete();
        popa = acca;
        check("a_rst_outval", 32'(outval_a), 32'd0);
        check("a_rst_outputs", 32'({outdata_a, outisk_a, phase_a}), 32'd0);
        check("a_rst_underflow", 32'(underflow_a), 32'd0);
      end else begin
        check("a_underflow", 32'(underflow_a), 32'(prev_v && !outval_a));
        if (outval_a) begin
          check("a_slice_expected", 32'(qa.size() != 0), 32'd1);
          if (qa.size() != 0) begin
            e = qa.pop_front();
            check("a_data", 32'(outdata_a), 32'(e.d));
            check("a_isk", 32'(outisk_a), 32'(e.k));
            check("a_phase", 32'(phase_a), 32'(e.ph));
            if (e.ph == 2'd0) popa++;
            $display("slice A data=%h isk=%b phase=%0d", outdata_a, outisk_a, phase_a);
          end
        end else begin
          check("a_idle_outputs", 32'({outdata_a, outisk_a, phase_a}), 32'd0);
          check("a_no_gap", 32'(acca - popa), 32'(acc_last_a));
        end
      end
      check("a_inready", 32'(inready_a), 32'(!reset && (acca - popa) < 4));
      prev_v = outval_a;
    end
  end

  // ------------------------------------------------------------------ monitor B
  initial begin : mon_b
    bit     rst_e;
    bit     prev_v;
    slice_t e;
    prev_v = 1'b0;
    forever begin
      @(posedge usrclk);
      rst_e = reset;
      @(negedge usrclk);
      if (rst_e) begin
        qb.delete();
        popb = accb;
        check("b_rst_outputs", 32'({outval_b, underflow_b, outdata_b, outisk_b, phase_b}), 32'd0);
      end else begin
        check("b_underflow", 32'(underflow_b), 32'(prev_v && !outval_b));
        if (outval_b) begin
          check("b_slice_expected", 32'(qb.size() != 0), 32'd1);
          if (qb.size() != 0) begin
            e = qb.pop_front();
            check("b_data", 32'(outdata_b), 32'(e.d));
            check("b_isk", 32'(outisk_b), 32'(e.k));
            check("b_phase", 32'(phase_b), 32'(e.ph));
            popb++;
            $display("slice B data=%h isk=%b phase=%0d", outdata_b, outisk_b, phase_b);
          end
        end else begin
          check("b_idle_outputs", 32'({outdata_b, outisk_b, phase_b}), 32'd0);
          check("b_no_gap", 32'(accb - popb), 32'(acc_last_b));
        end
      end
      check("b_inready", 32'(inready_b), 32'(!reset && (accb - popb) < 4));
      prev_v = outval_b;
    end
  end

  // ------------------------------------------------------------------ stimulus
  initial begin : stim
    bit          acc;
    logic [31:0] w;
    int          n;

    // Reset held for two edges
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(2);

    // Single word: AAAA/11 then BBBB/00, then underflow
    push_word(1'b0, 32'hBBBB_AAAA, 4'b0011);
    idle(5);

    // Continuous stream of four words, slices 0000..0007
    for (int i = 0; i < 4; i++)
      push_word(1'b0, {16'(2*i + 1), 16'(2*i)}, 4'(i * 5));
    idle(10);

    // Fill: inval held high with incrementing data
    w = 32'h0101_0100;
    for (int c = 0; c < 40; c++) begin
      step(1'b0, 1'b1, w, w[3:0], acc);
      if (acc) w = w + 32'h0002_0002;
    end
    idle(12);

    // Reset while slice 0 of 0x12345678 is shown with two words queued
    push_word(1'b0, 32'h1111_2222, 4'b0001);
    push_word(1'b0, 32'h1234_5678, 4'b0010);
    push_word(1'b0, 32'h3333_4444, 4'b0100);
    push_word(1'b0, 32'h5555_6666, 4'b1000);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    push_word(1'b0, 32'hCAFE_BABE, 4'b1001);
    idle(5);

    // div == 1: consecutive slices, phase stays 0
    push_word(1'b1, 32'h0000_1111, 4'b0001);
    push_word(1'b1, 32'h0000_2222, 4'b0010);
    idle(4);

    // Random words with random valid gaps; slices reproduce each word
    n = 0;
    for (int c = 0; c < 2000 && n < 200; c++) begin
      step(1'b0, $urandom_range(0, 3) != 0, $urandom, 4'($urandom), acc);
      if (acc) n++;
    end
    check("random_words_sent", 32'(n), 32'd200);

    // Drain both scoreboards (bounded)
    for (int c = 0; c < 100 && (qa.size() + qb.size()) != 0; c++) idle(1);
    check("drain", 32'(qa.size() + qb.size()), 32'd0);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gtxe2_chnl_tx_dataiface.md
# gtxe2_chnl_tx_dataiface

Transmit-side user data interface for the GTXE2 channel model. It accepts wide words (`interface_data_width` data plus `interface_isk_width` K-flags) through a valid/ready handshake and buffers them in a small FIFO. It then serialises each word, low slice first, into `div` narrow words (`internal_data_width`/`internal_isk_width`), one per `usrclk` cycle. The narrow words feed the TX encoder path. Slice ordering is the exact inverse of the RX data interface packing, so a loopback reproduces the original wide word.

## Interface
Parameters:
- `internal_data_width`, 16, narrow data width toward the encoder.
- `interface_data_width`, 32, wide user data width; `div = interface_data_width / internal_data_width`, an integer ≥ 1.
- `internal_isk_width`, 2, narrow K-flag width.
- `interface_isk_width`, 4, wide K-flag width; must equal `div * internal_isk_width`.
- `log_depth`, 2, FIFO depth is `2**log_depth` wide words.

Ports:
- `usrclk`  in  1  the only clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `indata`  in  `interface_data_width`  wide data word.
- `inisk`  in  `interface_isk_width`  wide K-flags.
- `inval`  in  1  producer has a word on `indata`/`inisk`.
- `inready`  out  1  FIFO can accept; the word transfers on an edge with `inval & inready`.
- `outdata`  out  `internal_data_width`  narrow data slice, registered.
- `outisk`  out  `internal_isk_width`  narrow K-flags slice, registered.
- `outval`  out  1  `outdata`/`outisk` carry a real slice.
- `phase`  out  `max(1,$clog2(div))`  index of the slice currently on `outdata`.
- `underflow`  out  1  one-cycle pulse when a stream stalls mid-run.

## Operation
- FIFO is single-clock, `2**log_depth` entries, with an occupancy counter of `log_depth+1` bits.
- Push happens when `inval & inready`. `inready = ~full & ~reset`.
- Pop is performed only by the serialiser. Push and pop on the same edge leave occupancy unchanged.
- Serialiser state is implied by `outval`:
  - IDLE: `outval = 0`.
  - RUN: `outval = 1`.
- Holding register `hold` is `interface_data_width + interface_isk_width` bits. Slice `i` is data bits `[(i+1)*internal_data_width-1 -: internal_data_width]` and isk bits `[(i+1)*internal_isk_width-1 -: internal_isk_width]`.
- On each edge, when not in reset:
  - **Load point.** Applies if in IDLE, or in RUN with `phase == div-1`.
    - If the FIFO is non-empty: pop the head into `hold`, drive slice 0 to the outputs, set `outval = 1` and `phase = 0`.
    - If the FIFO is empty: set `outdata = 0`, `outisk = 0`, `outval = 0`, `phase = 0`. If `outval` was 1 before this edge, assert `underflow` for one cycle.
  - **Otherwise** (RUN, `phase < div-1`): drive slice `phase+1` from `hold` and increment `phase`.
- `div == 1`: every RUN cycle is a load point, and `phase` stays 0.
- `underflow` never fires for the first IDLE→RUN start, nor during IDLE→IDLE.
- Occupancy uses the registered count. A word pushed into an empty FIFO is not poppable on the same edge.

## Timing
- Reset values:
  - `outdata = 0`, `outisk = 0`, `outval = 0`, `phase = 0`, `underflow = 0`.
  - FIFO is empty.
  - `inready = 0` while `reset` is high, and 1 on the first cycle after.
- Latency, when IDLE with an empty FIFO:
  - The word accepted at edge k shows slice 0 after edge k+1.
  - Slice `i` shows after edge k+1+i.
  - With nothing queued, `outval` drops after edge k+1+div, together with the `underflow` pulse.
- Throughput: one narrow slice per cycle. Back-to-back words produce no gap while the FIFO is non-empty at each load point.
- Full FIFO: `inready = 0`. `inval` is ignored, with no overflow and no data loss; the producer must hold the word.
- A pop on a full FIFO raises `inready` on the following cycle. A same-edge push against a full FIFO is not accepted.
- Reset asserted mid-word:
  - The partial word is discarded and the FIFO is flushed.
  - Outputs take reset values after that edge, and no `underflow` pulse is produced.

## Test plan
- **Single word.** Defaults; push `0xBBBBAAAA`, isk `4'b0011` at edge k.
  - After k+1: `AAAA`, `2'b11`, `phase = 0`, `outval = 1`.
  - After k+2: `BBBB`, `2'b00`, `phase = 1`.
  - After k+3: `outval = 0`, outputs 0, `underflow = 1` for one cycle.
- **Continuous stream.** Push 4 words `0x00010000`…`0x00070006`, one per edge while `inready`.
  - Required: 8 consecutive `outval` cycles carrying `0000,0001,…,0007`.
  - Single `underflow` only after the last slice.
- **Fill.** Hold `inval = 1` with incrementing data.
  - `inready` falls once occupancy reaches 4.
  - The output sequence is strictly incrementing, with no duplicate or missing words.
  - `inready` recovers exactly one cycle after each pop.
- **Reset mid-word.** Assert `reset` for one edge while `phase = 0` of word `0x12345678` with 2 words queued.
  - Required: outputs are 0 next cycle and the FIFO is empty.
  - The next pushed word `0xCAFEBABE` emits `BABE`, `CAFE`.
- **`div == 1`** (`interface_data_width = 16`, `interface_isk_width = 2`).
  - Pushes `0x1111`, `0x2222` emit the same values on consecutive cycles, with `phase = 0` throughout.
- **Loopback.** Feed the output into the RX data interface.
  - Random 200 words, including K-flags, are reproduced bit-exact.
